// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared CPU definitions.
//   - ALU opcode constants. DIV selects the multi-cycle seq_divider.
//   - State encoding for the sequential divider FSM.
//   - No ports; this file is imported by the datapath blocks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package cpu_pkg;

  // ALU opcodes (5-bit)
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_SHR = 5'b00111;
  localparam logic [4:0] ALU_SHL = 5'b01001;
  localparam logic [4:0] ALU_MUL = 5'b01110;
  localparam logic [4:0] ALU_DIV = 5'b01111;
  localparam logic [4:0] ALU_NEG = 5'b10000;
  localparam logic [4:0] ALU_NOT = 5'b10001;

  // Divider FSM state codes
  typedef logic [2:0] div_state_t;
  localparam div_state_t DIV_IDLE = 3'd0;
  localparam div_state_t DIV_PREP = 3'd1;
  localparam div_state_t DIV_ITER = 3'd2;
  localparam div_state_t DIV_FIX  = 3'd3;
  localparam div_state_t DIV_DONE = 3'd4;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//   The partial remainder is shifted left. The next dividend bit enters at the
//   bottom, and the divisor magnitude is trial-subtracted at WIDTH+1 bits.
//   Ports:
//     rem       in  WIDTH  current partial remainder (always < dmag)
//     q_msb     in  1      next dividend bit shifted in (MSB of the q register)
//     dmag      in  WIDTH  divisor magnitude (non-zero)
//     rem_next  out WIDTH  partial remainder after this step
//     q_bit     out 1      quotient bit produced by this step
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < dmag, so the shifted value is below 2*dmag and fits in WIDTH+1 bits.
  assign shifted  = {rem, q_msb};
  assign trial    = shifted - {1'b0, dmag};
  // A clear top bit means the trial difference is non-negative, so the subtraction is kept.
  assign q_bit    = ~trial[WIDTH];
  // When restoring, shifted < dmag, so its top bit is zero and dropping it is safe.
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle radix-2 restoring divider for signed or unsigned operands.
//   Division truncates toward zero, so the remainder takes the dividend's sign.
//   A zero divisor is flagged and gives quotient = all ones, remainder = dividend.
//   Ports:
//     Clock        in  1      rising-edge clock
//     Resetn       in  1      asynchronous active-low reset
//     start        in  1      request, sampled only while idle
//     is_signed    in  1      1 = two's-complement operands (captured with start)
//     dividend     in  WIDTH  numerator (captured with start)
//     divisor      in  WIDTH  denominator (captured with start)
//     busy         out 1      high from the cycle after acceptance through done
//     done         out 1      one-cycle pulse; results valid from this cycle
//     quotient     out WIDTH  quotient (to LO)
//     remainder    out WIDTH  remainder (to HI)
//     div_by_zero  out 1      divisor was zero; held until the next accepted start
//   Latency from the accepting edge: WIDTH+2 edges normally, 1 edge for divide-by-zero.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_reg, state_next;

  logic [WIDTH-1:0] dividend_reg, divisor_reg;
  logic             signed_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [WIDTH-1:0] rem_reg, q_reg, dmag_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q_bit;
  logic             divisor_zero;

  // The magnitude of MIN wraps to itself, which is 2^(WIDTH-1) read as unsigned.
  assign dividend_mag = (signed_reg && dividend_reg[WIDTH-1]) ? (WIDTH'(0) - dividend_reg) : dividend_reg;
  assign divisor_mag  = (signed_reg && divisor_reg[WIDTH-1])  ? (WIDTH'(0) - divisor_reg)  : divisor_reg;
  assign divisor_zero = (divisor_reg == '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_reg),
    .q_msb    (q_reg[WIDTH-1]),
    .dmag     (dmag_reg),
    .rem_next (step_rem),
    .q_bit    (step_q_bit)
  );

  // State register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= DIV_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DIV_IDLE: if (start) state_next = DIV_PREP;
      DIV_PREP: state_next = divisor_zero ? DIV_DONE : DIV_ITER;
      DIV_ITER: if (cnt_reg == LAST_ITER) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_DONE;
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state_reg != DIV_IDLE);
    done = (state_reg == DIV_DONE);
  end

  // Datapath
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      signed_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      rem_reg       <= '0;
      q_reg         <= '0;
      dmag_reg      <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            dividend_reg <= dividend;
            divisor_reg  <= divisor;
            signed_reg   <= is_signed;
            dbz_reg      <= 1'b0;
          end
        end
        DIV_PREP: begin
          neg_q_reg <= signed_reg & (dividend_reg[WIDTH-1] ^ divisor_reg[WIDTH-1]);
          neg_r_reg <= signed_reg & dividend_reg[WIDTH-1];
          if (divisor_zero) begin
            quotient_reg  <= '1;
            remainder_reg <= dividend_reg;
            dbz_reg       <= 1'b1;
          end else begin
            rem_reg  <= '0;
            q_reg    <= dividend_mag;
            dmag_reg <= divisor_mag;
            cnt_reg  <= '0;
          end
        end
        DIV_ITER: begin
          rem_reg <= step_rem;
          // Dividend bits leave at the top while quotient bits fill in at the bottom.
          q_reg   <= {q_reg[WIDTH-2:0], step_q_bit};
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        DIV_FIX: begin
          quotient_reg  <= neg_q_reg ? (WIDTH'(0) - q_reg)   : q_reg;
          remainder_reg <= neg_r_reg ? (WIDTH'(0) - rem_reg) : rem_reg;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
module tb_seq_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // 32-bit instance
  logic        start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, dbz;
  logic [31:0] quotient, remainder;

  // 8-bit instance
  logic        start8, signed8;
  logic [7:0]  dividend8, divisor8;
  logic        busy8, done8, dbz8;
  logic [7:0]  quotient8, remainder8;

  seq_divider #(.WIDTH(32)) u_dut (
    .Clock(clk), .Resetn(rst_n), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(dbz)
  );

  seq_divider #(.WIDTH(8)) u_dut8 (
    .Clock(clk), .Resetn(rst_n), .start(start8), .is_signed(signed8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic [31:0] dbz;
    int          accept;
    int          lat_min;
    int          lat_max;
  } exp_t;

  exp_t sb32[$];
  exp_t sb8[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Reference model: plain integer division on w-bit operands.
  // Truncating division is done in 64-bit arithmetic, so MIN / -1 simply wraps on masking.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, bit s);
    longint mask, ua, ub, sa, sb, qq, rr;
    exp_t   e;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    if (ub == 0) begin
      e.q = 32'(mask); e.r = 32'(ua); e.dbz = 1;
      e.lat_min = 1; e.lat_max = 2;
    end else begin
      if (s) begin
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      end else begin
        sa = ua; sb = ub;
      end
      qq = sa / sb;
      rr = sa % sb;
      e.q = 32'(qq & mask); e.r = 32'(rr & mask); e.dbz = 0;
      e.lat_min = w + 2; e.lat_max = w + 2;
    end
    e.accept = 0;
    return e;
  endfunction

  // Monitors: compare each done pulse with the oldest expected entry
  exp_t m32, m8;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb32.size() == 0) begin
        total++; bad++;
        $display("FAIL done32_unexpected: got done=1 expected no done");
      end else begin
        m32 = sb32.pop_front();
        check("q32", quotient, m32.q);
        check("r32", remainder, m32.r);
        check("dbz32", {31'd0, dbz}, m32.dbz);
        total++;
        if (cyc - m32.accept < m32.lat_min || cyc - m32.accept > m32.lat_max) begin
          bad++;
          $display("FAIL lat32: got %0d expected %0d..%0d", cyc - m32.accept, m32.lat_min, m32.lat_max);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done8 === 1'b1) begin
      if (sb8.size() == 0) begin
        total++; bad++;
        $display("FAIL done8_unexpected: got done=1 expected no done");
      end else begin
        m8 = sb8.pop_front();
        check("q8", {24'd0, quotient8}, m8.q);
        check("r8", {24'd0, remainder8}, m8.r);
        check("dbz8", {31'd0, dbz8}, m8.dbz);
        total++;
        if (cyc - m8.accept < m8.lat_min || cyc - m8.accept > m8.lat_max) begin
          bad++;
          $display("FAIL lat8: got %0d expected %0d..%0d", cyc - m8.accept, m8.lat_min, m8.lat_max);
        end
      end
    end
  end

  task automatic issue32(logic [31:0] a, logic [31:0] b, bit s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    if (busy) begin
      total++; bad++;
      $display("FAIL idle32_timeout: got busy=1 expected 0");
    end
    dividend = a; divisor = b; is_signed = s; start = 1'b1;
    e = model(32, a, b, s);
    e.accept = cyc + 1;
    sb32.push_back(e);
    @(negedge clk);
    start = 1'b0;
    // Scramble operands; the captured copy must be used.
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    check("dbz32_clear_on_accept", {31'd0, dbz}, 32'd0);
  endtask

  task automatic issue8(logic [7:0] a, logic [7:0] b, bit s);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    if (busy8) begin
      total++; bad++;
      $display("FAIL idle8_timeout: got busy=1 expected 0");
    end
    dividend8 = a; divisor8 = b; signed8 = s; start8 = 1'b1;
    e = model(8, {24'd0, a}, {24'd0, b}, s);
    e.accept = cyc + 1;
    sb8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    dividend8 = 8'($urandom); divisor8 = 8'($urandom);
    check("dbz8_clear_on_accept", {31'd0, dbz8}, 32'd0);
  endtask

  logic [31:0] ra, rb;
  int          sel;

  initial begin
    start = 0; is_signed = 0; dividend = 0; divisor = 0;
    start8 = 0; signed8 = 0; dividend8 = 0; divisor8 = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, dbz}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    issue32(32'h24, 32'h22, 0);
    issue32(32'hFFFFFFF9, 32'd2, 1);
    issue32(32'd7, 32'hFFFFFFFE, 1);
    issue32(32'h12345678, 32'd0, 0);
    issue32(32'd100, 32'd7, 0);
    issue32(32'h80000000, 32'hFFFFFFFF, 1);
    issue32(32'hFFFFFFFF, 32'h00010000, 0);
    issue32(32'h80000000, 32'h00000000, 1);

    // A start while busy must be ignored (no second done, result unchanged)
    issue32(32'h00001000, 32'd3, 0);
    repeat (8) @(negedge clk);
    dividend = 32'd999; divisor = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of an operation
    issue32(32'hDEADBEEF, 32'd17, 0);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_q", quotient, 32'd0);
    check("midrst_r", remainder, 32'd0);
    check("midrst_dbz", {31'd0, dbz}, 32'd0);
    sb32.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue32(32'hDEADBEEF, 32'd17, 0);

    // Randomised operations
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        3: rb = $urandom >> $urandom_range(1, 30);
        default: rb = $urandom;
      endcase
      issue32(ra, rb, 1'($urandom_range(0, 1)));
    end

    // Narrow instance
    issue8(8'h24, 8'h22, 0);
    issue8(8'hF9, 8'h02, 1);
    issue8(8'h07, 8'hFE, 1);
    issue8(8'h80, 8'hFF, 1);
    issue8(8'h5A, 8'h00, 1);
    for (int i = 0; i < 20; i++)
      issue8(8'($urandom), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    // Drain
    for (int n = 0; n < 200 && (sb32.size() != 0 || sb8.size() != 0); n++)
      @(negedge clk);
    if (sb32.size() != 0 || sb8.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending expected 0", sb32.size() + sb8.size());
    end
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
